// File: rtl/ndigit_scan_display_pkg.sv
// ndigit_scan_display_pkg: scan FSM state encoding and 7-segment patterns {G,F,E,D,C,B,A}
package ndigit_scan_display_pkg;
    typedef enum logic {BLANK, ON} state_e;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;
endpackage

// File: rtl/ndigit_scan_display_seg7_lut.sv
// seg7_lut: combinational BCD nibble to segment decoder, dash for non-decimal values
module seg7_lut
    import ndigit_scan_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = (nib_i > 4'd9) ? SEG_DASH : SEG_DIGITS[nib_i];
endmodule

// File: rtl/ndigit_scan_display.sv
// ndigit_scan_display: multiplexed N-digit 7-segment driver with tear-free loads; SEG_DIMMING_EN adds PWM brightness
module ndigit_scan_display
    import ndigit_scan_display_pkg::*;
#(
    parameter int NDIGIT       = 4,
    parameter int DIV_CYCLES   = 25000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZB          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SEG_DIMMING_EN
    input  logic [3:0]            bright,
`endif
    input  logic [4*NDIGIT-1:0]   bcd_in,
    input  logic [NDIGIT-1:0]     dp_in,
    input  logic                  load,
    output logic                  load_ack,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [NDIGIT-1:0]     anode,
    output logic                  frame_tick
);
    localparam int CW = $clog2(DIV_CYCLES);
    localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGIT - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    state_e                  state_q;
    logic [NDIGIT-1:0][3:0]  shadow_q, pend_q;
    logic [NDIGIT-1:0]       shadow_dp_q, pend_dp_q, anode_q, lz;
    logic                    pend_v_q, frame_tick_q, seg_dp_q, lit, z;
    logic [6:0]              seg_q, lut_seg;

    assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    assign idx_d = (cnt_q != CNT_LAST) ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // a load landing on the frame boundary is applied directly, so ack it in the same cycle
    assign load_ack   = frame_tick_q & (pend_v_q | load);
    assign frame_tick = frame_tick_q;
    assign anode      = anode_q;
    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;

    seg7_lut u_lut (.nib_i(shadow_q[idx_q]), .seg_o(lut_seg));

    always_comb begin
        lz = '0;
        z  = 1'b1;
        for (int i = NDIGIT - 1; i >= 0; i--) begin
            z     = z & (shadow_q[i] == 4'd0);
            lz[i] = z & (i != 0);
        end
    end

`ifdef SEG_DIMMING_EN
    logic [3:0] pwm_q;
    assign lit = (state_q == ON) && (pwm_q < bright);
    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + 1'b1;
    end
`else
    assign lit = (state_q == ON);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= BLANK;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_v_q     <= 1'b0;
            anode_q      <= '0;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= (cnt_d < CNT_BLANK) ? BLANK : ON;
            frame_tick_q <= (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
            anode_q      <= lit ? (NDIGIT'(1) << idx_q) : '0;
            seg_q        <= (lit && !(LZB != 0 && lz[idx_q])) ? lut_seg : SEG_OFF;
            seg_dp_q     <= lit && shadow_dp_q[idx_q];
            if (load_ack) begin
                shadow_q    <= load ? bcd_in : pend_q;
                shadow_dp_q <= load ? dp_in : pend_dp_q;
                pend_v_q    <= 1'b0;
            end else if (load) begin
                pend_q    <= bcd_in;
                pend_dp_q <= dp_in;
                pend_v_q  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ndigit_scan_display.sv
// tb_ndigit_scan_display: directed checks of scan timing, tear-free loads, blanking and reset
module tb_ndigit_scan_display;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [11:0] bcd_in = '0;
    logic [2:0]  dp_in = '0;
    logic        load_ack, seg_dp, frame_tick;
    logic [6:0]  seg;
    logic [2:0]  anode;
    int          tests = 0, errs = 0, acks = 0, n;

    always #5 clk = ~clk;

    ndigit_scan_display #(.NDIGIT(3), .DIV_CYCLES(8), .BLANK_CYCLES(2), .LZB(1)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .load_ack(load_ack), .seg(seg), .seg_dp(seg_dp), .anode(anode), .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ft(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
            acks += int'(load_ack);
        end while (!frame_tick && cnt < 100);
        chk("frame_tick_seen", frame_tick, 1);
    endtask

    task automatic pulse_load(input logic [11:0] v, input logic [2:0] dp);
        bcd_in = v;
        dp_in  = dp;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic show_frame(input int pre, input logic [6:0] e0, e1, e2, input logic [2:0] dp);
        step(pre);
        chk("d0_anode", anode, 3'b001);
        chk("d0_seg", seg, e0);
        chk("d0_dp", seg_dp, dp[0]);
        step(5);
        chk("blank_anode", anode, 0);
        chk("blank_seg", seg, 0);
        chk("blank_dp", seg_dp, 0);
        step(3);
        chk("d1_anode", anode, 3'b010);
        chk("d1_seg", seg, e1);
        chk("d1_dp", seg_dp, dp[1]);
        step(8);
        chk("d2_anode", anode, 3'b100);
        chk("d2_seg", seg, e2);
        chk("d2_dp", seg_dp, dp[2]);
    endtask

    initial begin
        step(3);
        chk("rst_anode", anode, 0);
        chk("rst_seg", seg, 0);
        chk("rst_ft", frame_tick, 0);
        chk("rst_ack", load_ack, 0);
        rst = 1'b0;
        step();
        chk("rel1_anode", anode, 0);
        step();
        chk("rel2_anode", anode, 0);
        step();
        chk("rel3_anode", anode, 3'b001);
        chk("rel3_seg", seg, 7'h3F);
        wait_ft(n);
        chk("first_ft_at", n, 20);
        wait_ft(n);
        chk("ft_period", n, 24);
        // mid-frame load waits for the boundary
        step(3);
        acks = 0;
        pulse_load(12'h305, 3'b010);
        chk("mid_no_ack", load_ack, 0);
        wait_ft(n);
        chk("305_ack", load_ack, 1);
        chk("305_acks", acks, 1);
        show_frame(5, 7'h6D, 7'h3F, 7'h4F, 3'b010);
        wait_ft(n);
        chk("idle_no_ack", load_ack, 0);
        step(3);
        pulse_load(12'h007, 3'b000);
        wait_ft(n);
        chk("007_ack", load_ack, 1);
        show_frame(5, 7'h07, 7'h00, 7'h00, 3'b000);
        // last request wins, single ack
        wait_ft(n);
        step(3);
        acks = 0;
        pulse_load(12'h1A1, 3'b111);
        step();
        pulse_load(12'h123, 3'b000);
        wait_ft(n);
        chk("123_acks", acks, 1);
        show_frame(5, 7'h4F, 7'h5B, 7'h06, 3'b000);
        // load coincident with frame_tick is applied at that boundary
        wait_ft(n);
        bcd_in = 12'h0B4;
        dp_in  = 3'b001;
        load   = 1'b1;
        #1;
        chk("bypass_ack", load_ack, 1);
        step();
        load = 1'b0;
        show_frame(4, 7'h66, 7'h40, 7'h00, 3'b001);
        wait_ft(n);
        chk("bypass_no_reack", load_ack, 0);
        // reset discards a pending load
        step(3);
        pulse_load(12'h999, 3'b111);
        step(2);
        rst = 1'b1;
        step();
        chk("mrst_anode", anode, 0);
        chk("mrst_seg", seg, 0);
        chk("mrst_dp", seg_dp, 0);
        chk("mrst_ack", load_ack, 0);
        rst  = 1'b0;
        acks = 0;
        step(3);
        chk("mrst_d0_anode", anode, 3'b001);
        chk("mrst_d0_seg", seg, 7'h3F);
        step(8);
        chk("mrst_d1_anode", anode, 3'b010);
        chk("mrst_d1_seg", seg, 0);
        wait_ft(n);
        chk("mrst_ft_at", n, 12);
        step(30);
        chk("mrst_acks", acks, 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
